// File: rtl/mem_bist_master.sv
// Memory BIST initiator: writes a selectable pattern to every address, reads each one back,
// and reports pass/fail, the failure count and the first failing address/data.
module mem_bist_master #(
  parameter int                ADDR_W  = 4,
  parameter int                DATA_W  = 32,
  parameter int                TIMEOUT = 8,
  parameter logic [DATA_W-1:0] SEED    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        pat_sel,
  output logic              en,
  output logic              re,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  input  logic              valid_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   fail_cnt,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic [DATA_W-1:0] first_fail_data,
  output logic              timeout_err
);

  localparam int                WAIT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [ADDR_W:0]   FAIL_ONE  = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_REQ,
    S_RD_WAIT,
    S_DONE
  } state_t;

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0]        sel,
                                                input logic [ADDR_W-1:0] a);
    case (sel)
      2'd0:    pattern = '0;
      2'd1:    pattern = '1;
      2'd2:    pattern = a[0] ? {(DATA_W/2){2'b01}} : {(DATA_W/2){2'b10}};
      default: pattern = {{(DATA_W-ADDR_W){1'b0}}, a} ^ SEED;
    endcase
  endfunction

  state_t              state_q;
  logic [1:0]          pat_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [WAIT_W-1:0]   wait_q;
  logic                en_q;
  logic                re_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_in_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic [ADDR_W:0]     fail_cnt_q;
  logic [ADDR_W-1:0]   ffa_q;
  logic [DATA_W-1:0]   ffd_q;
  logic                tmo_q;

  logic                rd_resolve_d;
  logic                rd_fail_d;
  logic                rd_tmo_d;
  logic                first_fail_d;
  logic [ADDR_W:0]     fail_cnt_d;
  logic [ADDR_W-1:0]   cnt_inc_d;
  logic [DATA_W-1:0]   next_pat_d;

  // A read resolves either on valid_out or when the wait budget runs out.
  always_comb begin
    rd_resolve_d = 1'b0;
    rd_fail_d    = 1'b0;
    rd_tmo_d     = 1'b0;
    if (state_q == S_RD_WAIT) begin
      if (valid_out) begin
        rd_resolve_d = 1'b1;
        rd_fail_d    = (data_out != pattern(pat_q, cnt_q));
      end else if (wait_q == WAIT_LAST) begin
        rd_resolve_d = 1'b1;
        rd_fail_d    = 1'b1;
        rd_tmo_d     = 1'b1;
      end
    end
    fail_cnt_d   = rd_fail_d ? (fail_cnt_q + FAIL_ONE) : fail_cnt_q;
    first_fail_d = rd_fail_d && (fail_cnt_q == '0);
    cnt_inc_d    = cnt_q + ADDR_ONE;
    next_pat_d   = pattern(pat_q, cnt_inc_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pat_q      <= '0;
      cnt_q      <= '0;
      wait_q     <= '0;
      en_q       <= 1'b0;
      re_q       <= 1'b0;
      addr_q     <= '0;
      data_in_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_cnt_q <= '0;
      ffa_q      <= '0;
      ffd_q      <= '0;
      tmo_q      <= 1'b0;
    end else if (abort) begin
      // Results stay frozen so the partial outcome can still be inspected.
      state_q   <= S_IDLE;
      en_q      <= 1'b0;
      re_q      <= 1'b0;
      addr_q    <= '0;
      data_in_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q    <= S_WRITE;
            pat_q      <= pat_sel;
            cnt_q      <= '0;
            fail_cnt_q <= '0;
            ffa_q      <= '0;
            ffd_q      <= '0;
            tmo_q      <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            busy_q     <= 1'b1;
            en_q       <= 1'b1;
            re_q       <= 1'b0;
            addr_q     <= '0;
            data_in_q  <= pattern(pat_sel, '0);
          end
        end
        S_WRITE: begin
          if (cnt_q == LAST_ADDR) begin
            state_q   <= S_RD_REQ;
            cnt_q     <= '0;
            re_q      <= 1'b1;
            addr_q    <= '0;
            data_in_q <= '0;
          end else begin
            cnt_q     <= cnt_inc_d;
            addr_q    <= cnt_inc_d;
            data_in_q <= next_pat_d;
          end
        end
        S_RD_REQ: begin
          state_q <= S_RD_WAIT;
          en_q    <= 1'b0;
          re_q    <= 1'b0;
          wait_q  <= '0;
        end
        S_RD_WAIT: begin
          if (rd_resolve_d) begin
            fail_cnt_q <= fail_cnt_d;
            if (first_fail_d) begin
              ffa_q <= cnt_q;
              ffd_q <= rd_tmo_d ? '0 : data_out;
            end
            if (rd_tmo_d) tmo_q <= 1'b1;
            if (cnt_q == LAST_ADDR) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (fail_cnt_d == '0) && !(tmo_q || rd_tmo_d);
              addr_q  <= '0;
            end else begin
              state_q <= S_RD_REQ;
              cnt_q   <= cnt_inc_d;
              en_q    <= 1'b1;
              re_q    <= 1'b1;
              addr_q  <= cnt_inc_d;
            end
          end else begin
            wait_q <= wait_q + WAIT_ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign en              = en_q;
  assign re              = re_q;
  assign addr            = addr_q;
  assign data_in         = data_in_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign fail_cnt        = fail_cnt_q;
  assign first_fail_addr = ffa_q;
  assign first_fail_data = ffd_q;
  assign timeout_err     = tmo_q;

endmodule
